// File: rtl/spi_cmd_arbiter_if.sv
// Bus bundle between the SPI command arbiter, its requesters and spi_master.
// The slave modport is the arbiter's view; master is the environment's view
// (requesting sequencers plus the shared spi_master).
interface spi_cmd_arbiter_if #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]                 i_req;
  logic [NUM_REQ-1:0]                 i_rd;
  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] i_wr_data;
  logic [NUM_REQ-1:0]                 o_grant;
  logic [NUM_REQ-1:0]                 o_done;
  logic [MISO_DATA_WIDTH-1:0]         o_rd_data;
  logic                               o_timeout;
  logic                               o_spi_wr_cmd;
  logic                               o_spi_rd_cmd;
  logic [MOSI_DATA_WIDTH-1:0]         o_spi_wr_data;
  logic [MISO_DATA_WIDTH-1:0]         i_spi_rd_data;
  logic                               i_spi_busy;
  logic                               i_spi_cs_n;
  logic [NUM_REQ-1:0]                 o_cs_n;

  modport slave (
    input  i_req, i_rd, i_wr_data, i_spi_rd_data, i_spi_busy, i_spi_cs_n,
    output o_grant, o_done, o_rd_data, o_timeout,
           o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data, o_cs_n
  );

  modport master (
    output i_req, i_rd, i_wr_data, i_spi_rd_data, i_spi_busy, i_spi_cs_n,
    input  o_grant, o_done, o_rd_data, o_timeout,
           o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data, o_cs_n
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among NUM_REQ
// configuration requesters (0 = AD9517, 1 = ADC0, 2 = ADC1).
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transactions that
// keep the master busy for TIMEOUT_CYCLES clocks.
module spi_cmd_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic             clk,
  input  logic             nrst,
  spi_cmd_arbiter_if.slave bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE} state_t;

  state_t                     state, state_nxt;
  logic [IDXW-1:0]            last, sel, cand;
  logic                       found, any_req, rd_q, to_hit, to_q;
  logic [NUM_REQ-1:0]         grant, sel_oh;
  logic [MOSI_DATA_WIDTH-1:0] wr_data_q, sel_wr_data;
  logic [MISO_DATA_WIDTH-1:0] rd_data_q;

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] v);
    return (v == IDXW'(NUM_REQ-1)) ? '0 : v + IDXW'(1);
  endfunction

  assign any_req = |bus.i_req;

  // Rotating priority: first requester found searching upward from last+1
  always_comb begin
    sel   = last;
    found = 1'b0;
    cand  = wrap_inc(last);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.i_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  // Decode the winner into a one-hot grant and pick its write word
  always_comb begin
    sel_oh      = '0;
    sel_wr_data = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (sel == IDXW'(n)) begin
        sel_oh[n]   = 1'b1;
        sel_wr_data = bus.i_wr_data[n*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] to_cnt;

  // Watchdog counts cycles spent waiting on the master; it is zero during
  // ISSUE, so firing at TIMEOUT_CYCLES-2 lands COMPLETE exactly
  // TIMEOUT_CYCLES cycles after the command strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                       to_cnt <= '0;
    else if (state == IDLE && any_req)               to_cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_DONE) to_cnt <= to_cnt + CW'(1);
  end

  assign to_hit = (state == WAIT_BUSY || state == WAIT_DONE) &&
                  (to_cnt == CW'(TIMEOUT_CYCLES-2));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: issue, ride out the busy window, then complete
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (to_hit) state_nxt = COMPLETE;
                 else if (bus.i_spi_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (to_hit || !bus.i_spi_busy) state_nxt = COMPLETE;
      COMPLETE:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant/latch the winner's transaction, capture read data on busy fall
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant     <= '0;
      last      <= IDXW'(NUM_REQ-1);
      wr_data_q <= '0;
      rd_q      <= 1'b0;
      rd_data_q <= '0;
      to_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant     <= sel_oh;
          last      <= sel;
          wr_data_q <= sel_wr_data;
          rd_q      <= bus.i_rd[sel];
          to_q      <= 1'b0;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (to_hit) begin
            rd_data_q <= '1;
            to_q      <= 1'b1;
          end else if (state == WAIT_DONE && !bus.i_spi_busy && rd_q) begin
            rd_data_q <= bus.i_spi_rd_data;
          end
        end
        COMPLETE: grant <= '0;
        default: ;
      endcase
    end
  end

  assign bus.o_grant       = grant;
  assign bus.o_done        = (state == COMPLETE) ? grant : '0;
  assign bus.o_timeout     = (state == COMPLETE) && to_q;
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_spi_wr_cmd  = (state == ISSUE) && !rd_q;
  assign bus.o_spi_rd_cmd  = (state == ISSUE) && rd_q;
  assign bus.o_spi_wr_data = wr_data_q;

  // Only the owner sees the master's chip-select; everyone else stays high
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_cs
    assign bus.o_cs_n[n] = grant[n] ? bus.i_spi_cs_n : 1'b1;
  end
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter: a behavioural spi_master with
// random start delay and busy length, plus a round-robin reference model
// of the requesters.
module tb_spi_cmd_arbiter;
  logic clk = 1'b0;
  logic nrst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_cmd_arbiter_if #(.NUM_REQ(3), .MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8)) bus ();

  spi_cmd_arbiter #(
    .NUM_REQ(3), .MOSI_DATA_WIDTH(24), .MISO_DATA_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut (.clk(clk), .nrst(nrst), .bus(bus));

  // spi_master model: responds to a strobe with a random start delay, then
  // a random busy window with cs_n low; read data appears as busy falls.
  bit         hold_busy = 1'b0;
  logic [7:0] m_next_rd = '0;
  int         m_fall_cyc = 0;
  int         m_phase = 0, m_dcnt = 0, m_bcnt = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      m_phase = 0;
      #1;
      bus.i_spi_busy = 1'b0;
      bus.i_spi_cs_n = 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.o_spi_wr_cmd || bus.o_spi_rd_cmd) begin
             m_dcnt  = $urandom_range(0, 3);
             m_bcnt  = $urandom_range(1, 6);
             m_phase = 1;
           end
        1: if (m_dcnt == 0) begin
             m_phase = 2;
             #1;
             bus.i_spi_busy = 1'b1;
             bus.i_spi_cs_n = 1'b0;
           end else m_dcnt--;
        2: if (!hold_busy) begin
             if (m_bcnt == 0) begin
               m_phase    = 0;
               m_fall_cyc = cyc;
               #1;
               bus.i_spi_busy    = 1'b0;
               bus.i_spi_cs_n    = 1'b1;
               bus.i_spi_rd_data = m_next_rd;
             end else m_bcnt--;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Observations of one transaction, filled by run_txn
  bit          r_got;
  logic [2:0]  r_done, r_sg, r_csw;
  logic [7:0]  r_rdv;
  logic        r_tmo, r_sw, r_sr;
  logic [23:0] r_sd, r_wdend;
  int          r_dcyc, r_nstb, r_scyc;

  // Watch one transaction up to its o_done (bounded). With scramble set, the
  // owner's inputs are disturbed after the strobe to prove they are latched.
  task automatic run_txn(input int budget, input bit scramble);
    r_got = 0; r_nstb = 0; r_scyc = -1; r_csw = 3'b111; r_done = '0;
    r_sg = '0; r_sw = 0; r_sr = 0; r_sd = '0; r_rdv = '0; r_tmo = 0;
    r_dcyc = -1; r_wdend = '0;
    for (int i = 0; i < budget && !r_got; i++) begin
      @(negedge clk);
      if (bus.o_spi_wr_cmd || bus.o_spi_rd_cmd) begin
        r_nstb++;
        r_scyc = cyc; r_sw = bus.o_spi_wr_cmd; r_sr = bus.o_spi_rd_cmd;
        r_sd = bus.o_spi_wr_data; r_sg = bus.o_grant;
        if (scramble)
          for (int n = 0; n < 3; n++)
            if (r_sg[n]) begin
              bus.i_wr_data[n*24 +: 24] = 24'($urandom);
              bus.i_rd[n] = ~bus.i_rd[n];
              if ($urandom_range(0, 1) == 1) bus.i_req[n] = 1'b0;
            end
      end
      if (bus.i_spi_cs_n == 1'b0) r_csw = bus.o_cs_n;
      if (bus.o_done != '0) begin
        r_got = 1; r_done = bus.o_done; r_rdv = bus.o_rd_data;
        r_tmo = bus.o_timeout; r_dcyc = cyc; r_wdend = bus.o_spi_wr_data;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.o_grant !== 3'b000) begin errors++; $display("FAIL rst_grant got %b want 000", bus.o_grant); end
    checks++; if (bus.o_done !== 3'b000) begin errors++; $display("FAIL rst_done got %b want 000", bus.o_done); end
    checks++; if (bus.o_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", bus.o_rd_data); end
    checks++; if (bus.o_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", bus.o_timeout); end
    checks++; if ({bus.o_spi_wr_cmd, bus.o_spi_rd_cmd} !== 2'b00) begin errors++; $display("FAIL rst_cmds got %b want 00", {bus.o_spi_wr_cmd, bus.o_spi_rd_cmd}); end
    checks++; if (bus.o_spi_wr_data !== 24'h0) begin errors++; $display("FAIL rst_wr_data got %h want 000000", bus.o_spi_wr_data); end
    checks++; if (bus.o_cs_n !== 3'b111) begin errors++; $display("FAIL rst_cs_n got %b want 111", bus.o_cs_n); end
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_grant !== 3'b000) begin errors++; $display("FAIL idle_grant got %b want 000", bus.o_grant); end
  endtask

  task automatic test_single_write();
    bus.i_wr_data[24 +: 24] = 24'h000A5C;
    bus.i_rd[1] = 1'b0;
    bus.i_req = 3'b010;
    m_next_rd = 8'h33;
    run_txn(60, 1);
    bus.i_req[1] = 1'b0;
    checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL wr_done_seen got %0d want 1", r_got); end
    checks++; if (r_nstb != 1) begin errors++; $display("FAIL wr_strobe_count got %0d want 1", r_nstb); end
    checks++; if ({r_sw, r_sr} !== 2'b10) begin errors++; $display("FAIL wr_strobe_kind got %b want 10", {r_sw, r_sr}); end
    checks++; if (r_sd !== 24'h000A5C) begin errors++; $display("FAIL wr_data got %h want 000a5c", r_sd); end
    checks++; if (r_wdend !== 24'h000A5C) begin errors++; $display("FAIL wr_data_held got %h want 000a5c", r_wdend); end
    checks++; if (r_sg !== 3'b010) begin errors++; $display("FAIL wr_grant got %b want 010", r_sg); end
    checks++; if (r_csw !== 3'b101) begin errors++; $display("FAIL wr_cs_n got %b want 101", r_csw); end
    checks++; if (r_done !== 3'b010) begin errors++; $display("FAIL wr_done got %b want 010", r_done); end
    checks++; if (r_dcyc != m_fall_cyc + 1) begin errors++; $display("FAIL wr_done_cycle got %0d want %0d", r_dcyc, m_fall_cyc + 1); end
    checks++; if (r_rdv !== 8'h00) begin errors++; $display("FAIL wr_rd_data_hold got %h want 00", r_rdv); end
    checks++; if (r_tmo !== 1'b0) begin errors++; $display("FAIL wr_timeout got %b want 0", r_tmo); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.i_wr_data[0 +: 24] = 24'h800500;
    bus.i_rd[0] = 1'b1;
    bus.i_req = 3'b001;
    m_next_rd = 8'h7E;
    run_txn(60, 0);
    bus.i_req[0] = 1'b0;
    checks++; if ({r_sw, r_sr} !== 2'b01) begin errors++; $display("FAIL rd_strobe_kind got %b want 01", {r_sw, r_sr}); end
    checks++; if (r_sg !== 3'b001) begin errors++; $display("FAIL rd_grant got %b want 001", r_sg); end
    checks++; if (r_csw !== 3'b110) begin errors++; $display("FAIL rd_cs_n got %b want 110", r_csw); end
    checks++; if (r_done !== 3'b001) begin errors++; $display("FAIL rd_done got %b want 001", r_done); end
    checks++; if (r_rdv !== 8'h7E) begin errors++; $display("FAIL rd_data got %h want 7e", r_rdv); end
    checks++; if (r_dcyc != m_fall_cyc + 1) begin errors++; $display("FAIL rd_done_cycle got %0d want %0d", r_dcyc, m_fall_cyc + 1); end
  endtask

  task automatic test_round_robin();
    int prev;
    logic [2:0] exp;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      bus.i_wr_data[n*24 +: 24] = 24'($urandom);
      bus.i_rd[n] = 1'($urandom_range(0, 1));
    end
    bus.i_req = 3'b111;
    prev = cyc - 1;
    for (int k = 0; k < 6; k++) begin
      m_next_rd = 8'($urandom);
      run_txn(60, 0);
      exp = 3'b001 << (k % 3);
      checks++; if (r_sg !== exp) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, r_sg, exp); end
      checks++; if (r_done !== exp) begin errors++; $display("FAIL rr_done[%0d] got %b want %b", k, r_done, exp); end
      checks++; if (r_scyc != prev + 2) begin errors++; $display("FAIL rr_strobe_cycle[%0d] got %0d want %0d", k, r_scyc, prev + 2); end
      prev = r_dcyc;
    end
    bus.i_req = '0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bit bad = 0;
    do_reset();
    hold_busy = 1'b1;
    bus.i_wr_data[48 +: 24] = 24'h8A0000;
    bus.i_rd[2] = 1'b1;
    bus.i_req = 3'b100;
    m_next_rd = 8'hC3;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.i_spi_cs_n == 1'b0) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_busy_seen got 0 want 1"); end
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++; if (bus.o_grant !== 3'b000) begin errors++; $display("FAIL mid_rst_grant got %b want 000", bus.o_grant); end
    checks++; if (bus.o_cs_n !== 3'b111) begin errors++; $display("FAIL mid_rst_cs_n got %b want 111", bus.o_cs_n); end
    checks++; if (bus.o_spi_wr_data !== 24'h0) begin errors++; $display("FAIL mid_rst_wr_data got %h want 000000", bus.o_spi_wr_data); end
    for (int i = 0; i < 3; i++) begin
      if (bus.o_done !== 3'b000) bad = 1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++; $display("FAIL mid_rst_no_done got pulse want none"); end
    hold_busy = 1'b0;
    nrst = 1'b1;
    run_txn(60, 0);
    bus.i_req = '0;
    checks++; if (r_sg !== 3'b100) begin errors++; $display("FAIL mid_regrant got %b want 100", r_sg); end
    checks++; if (r_done !== 3'b100) begin errors++; $display("FAIL mid_done got %b want 100", r_done); end
    checks++; if (r_rdv !== 8'hC3) begin errors++; $display("FAIL mid_rd_data got %h want c3", r_rdv); end
  endtask

  task automatic test_random();
    logic [2:0]  req_m;
    logic [23:0] data_m [3];
    bit          rd_m [3];
    logic [7:0]  exp_rd = 8'h00;
    int          last_m = 2;
    int          c, prev;
    do_reset();
    req_m = '0;
    for (int k = 0; k < 40; k++) begin
      // requesters: any idle channel may raise a fresh request
      for (int n = 0; n < 3; n++)
        if (!req_m[n] && $urandom_range(0, 1) == 1) req_m[n] = 1'b1;
      if (req_m == '0) req_m[$urandom_range(0, 2)] = 1'b1;
      for (int n = 0; n < 3; n++)
        if (req_m[n] && !bus.i_req[n]) begin
          data_m[n] = 24'($urandom);
          rd_m[n]   = 1'($urandom_range(0, 1));
          bus.i_wr_data[n*24 +: 24] = data_m[n];
          bus.i_rd[n] = rd_m[n];
          bus.i_req[n] = 1'b1;
        end
      if (k == 0) prev = cyc - 1;
      m_next_rd = 8'($urandom);
      c = -1;
      for (int i = 1; i <= 3; i++)
        if (c < 0 && req_m[(last_m + i) % 3]) c = (last_m + i) % 3;
      run_txn(60, 1);
      checks++; if (r_sg !== 3'(1 << c)) begin errors++; $display("FAIL rnd_grant[%0d] got %b want %b", k, r_sg, 3'(1 << c)); end
      checks++; if ({r_sw, r_sr} !== (rd_m[c] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rnd_kind[%0d] got %b want rd=%0d", k, {r_sw, r_sr}, rd_m[c]); end
      checks++; if (r_sd !== data_m[c] || r_wdend !== data_m[c]) begin errors++; $display("FAIL rnd_wr_data[%0d] got %h/%h want %h", k, r_sd, r_wdend, data_m[c]); end
      if (rd_m[c]) exp_rd = m_next_rd;
      checks++; if (r_done !== 3'(1 << c) || r_rdv !== exp_rd) begin errors++; $display("FAIL rnd_done[%0d] got %b/%h want %b/%h", k, r_done, r_rdv, 3'(1 << c), exp_rd); end
      checks++; if (r_dcyc != m_fall_cyc + 1 || r_scyc != prev + 2 || r_nstb != 1) begin errors++; $display("FAIL rnd_timing[%0d] got d%0d s%0d n%0d want d%0d s%0d n1", k, r_dcyc, r_scyc, r_nstb, m_fall_cyc + 1, prev + 2); end
      prev = r_dcyc;
      last_m = c;
      req_m[c] = 1'b0;
      bus.i_req[c] = 1'b0;
    end
    bus.i_req = '0;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    hold_busy = 1'b1;
    bus.i_rd[0] = 1'b0;
    bus.i_req = 3'b001;
    run_txn(60, 0);
    bus.i_req = '0;
    checks++; if (r_done !== 3'b001 || r_tmo !== 1'b1) begin errors++; $display("FAIL to_pulse got %b/%b want 001/1", r_done, r_tmo); end
    checks++; if (r_dcyc != r_scyc + 16) begin errors++; $display("FAIL to_cycle got %0d want %0d", r_dcyc, r_scyc + 16); end
    checks++; if (r_rdv !== 8'hFF) begin errors++; $display("FAIL to_rd_data got %h want ff", r_rdv); end
    hold_busy = 1'b0;
    do_reset();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    nrst = 1'b0;
    bus.i_req = '0; bus.i_rd = '0; bus.i_wr_data = '0;
    bus.i_spi_busy = 1'b0; bus.i_spi_cs_n = 1'b1; bus.i_spi_rd_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_reset_mid();
    test_random();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
